// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI target with APB-visible instruction, TX/RX buffers and status
//
// Ports:
//   pclk_i, presetn_i        system clock, synchronous active-low reset
//   paddr_i..pwdata_i        APB slave (zero wait states, pready_o tied 1)
//   prdata_o                 registered APB read data
//   sclk_i, cs_i, mosi_i     SPI inputs from the master (oversampled in pclk)
//   miso_o                   SPI output to the master, idles high
//   irq_o                    level interrupt, present only with SPI_SLAVE_IRQ_EN
//
// Optional feature macro: SPI_SLAVE_IRQ_EN (adds irq_o and IRQEN register at 0x07).
//
// Register map: 0x00 INSTR, 0x01-0x05 TX, 0x06 RXCNT, 0x07 IRQEN (optional),
//               0x08 STATUS {overrun, done, busy}, 0x09-0x0D RX.

module spi_slave #(
  parameter int MAX_BYTES   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk_i,
  input  logic       presetn_i,
  input  logic [7:0] paddr_i,
  input  logic       psel_i,
  input  logic       penable_i,
  input  logic       pwrite_i,
  input  logic [7:0] pwdata_i,
  output logic       pready_o,
  output logic [7:0] prdata_o,
  input  logic       sclk_i,
  input  logic       cs_i,
  input  logic       mosi_i,
`ifdef SPI_SLAVE_IRQ_EN
  output logic       irq_o,
`endif
  output logic       miso_o
);

  localparam int IDXW = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // SCLK and CS chains reset to their idle level (high) so that leaving reset
  // with the bus idle never looks like an edge.
  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // SCLK activity only counts while the target is selected
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Frame state and buffers
  state_e            state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [IDXW-1:0]   byte_idx_q;
  logic [IDXW-1:0]   rxcnt_q;
  logic [7:0]        instr_q;
  logic [7:0]        tx_q [MAX_BYTES];
  logic [7:0]        rx_q [MAX_BYTES];
  logic              done_q;
  logic              ovr_q;
  logic              miso_q;
  logic [7:0]        prdata_q;

  logic       busy;
  logic       apb_wr, apb_rd;
  logic       clr_done, clr_ovr;
  logic [7:0] shift_in;
  logic       byte_full;
  logic       tx_bit_d;
  logic [7:0] rdata_d;

  assign busy      = (state_q != S_IDLE);
  assign apb_wr    = psel_i & penable_i & pwrite_i;
  assign apb_rd    = psel_i & penable_i & ~pwrite_i;
  assign clr_done  = apb_wr & (paddr_i == 8'h08) & pwdata_i[1];
  assign clr_ovr   = apb_wr & (paddr_i == 8'h08) & pwdata_i[2];
  assign shift_in  = {shift_q[6:0], mosi_s};
  assign byte_full = (byte_idx_q == IDXW'(MAX_BYTES));

  // Next MISO bit: MSB-first bit of the current TX byte, or idle-high once
  // every buffered byte has been sent.
  always_comb begin
    tx_bit_d = 1'b1;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byte_idx_q == IDXW'(i)) tx_bit_d = tx_q[i][~bit_cnt_q];
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      rxcnt_q    <= '0;
      instr_q    <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      miso_q     <= 1'b1;
      for (int i = 0; i < MAX_BYTES; i++) begin
        tx_q[i] <= '0;
        rx_q[i] <= '0;
      end
    end else begin
      // Host side: TX buffer is frozen for the whole frame
      if (apb_wr && !busy) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (paddr_i == 8'(i + 1)) tx_q[i] <= pwdata_i;
        end
      end

      // W1C clears come first so a same-cycle set from the FSM wins
      if (clr_done) done_q <= 1'b0;
      if (clr_ovr)  ovr_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          miso_q <= 1'b1;
          if (cs_fall) begin
            state_q    <= S_INSTR;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            rxcnt_q    <= '0;
          end
        end

        S_INSTR: begin
          miso_q <= 1'b1;
          if (cs_rise) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (sclk_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              instr_q <= shift_in;
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (cs_rise) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            miso_q  <= 1'b1;
          end else begin
            if (sclk_fall) miso_q <= tx_bit_d;
            if (sclk_rise) begin
              shift_q   <= shift_in;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_full) begin
                  ovr_q <= 1'b1;
                end else begin
                  for (int i = 0; i < MAX_BYTES; i++) begin
                    if (byte_idx_q == IDXW'(i)) rx_q[i] <= shift_in;
                  end
                  rxcnt_q    <= rxcnt_q + IDXW'(1);
                  byte_idx_q <= byte_idx_q + IDXW'(1);
                end
              end
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          miso_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic [1:0] irqen_q;
  logic       irq_q;

  // Computed from the registered flags, so a W1C clear drops irq one cycle later
  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (apb_wr && (paddr_i == 8'h07)) irqen_q <= pwdata_i[1:0];
      irq_q <= |({ovr_q, done_q} & irqen_q);
    end
  end

  assign irq_o = irq_q;
`endif

  // Read mux
  always_comb begin
    rdata_d = '0;
    if (paddr_i == 8'h00) rdata_d = instr_q;
    if (paddr_i == 8'h06) rdata_d = 8'(rxcnt_q);
    if (paddr_i == 8'h08) rdata_d = {5'b0, ovr_q, done_q, busy};
`ifdef SPI_SLAVE_IRQ_EN
    if (paddr_i == 8'h07) rdata_d = {6'b0, irqen_q};
`endif
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (paddr_i == 8'(i + 1)) rdata_d = tx_q[i];
      if (paddr_i == 8'(i + 9)) rdata_d = rx_q[i];
    end
  end

  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      prdata_q <= '0;
    end else if (apb_rd) begin
      prdata_q <= rdata_d;
    end
  end

  assign pready_o = 1'b1;
  assign prdata_o = prdata_q;
  assign miso_o   = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave

module tb_spi_slave;

  logic       pclk;
  logic       presetn;
  logic [7:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
`ifdef SPI_SLAVE_IRQ_EN
  logic       irq;
`endif

  spi_slave #(.MAX_BYTES(5), .SYNC_STAGES(2)) dut (
    .pclk_i    (pclk),
    .presetn_i (presetn),
    .paddr_i   (paddr),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pready_o  (pready),
    .prdata_o  (prdata),
    .sclk_i    (sclk),
    .cs_i      (cs),
    .mosi_i    (mosi),
`ifdef SPI_SLAVE_IRQ_EN
    .irq_o     (irq),
`endif
    .miso_o    (miso)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vec_cnt = 0;
  int miscmp  = 0;

  // Reference model of the host-visible state
  logic [7:0] tx_m [5];
  logic [7:0] rx_m [5];
  logic [7:0] instr_m;
  logic [7:0] rxcnt_m;
  logic       done_m;
  logic       ovr_m;
  logic [1:0] irqen_m;

  logic [7:0] mo_buf [16];
  logic [7:0] mi_buf [16];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] val;   // write data, or expected read data
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      tx_m[i] = 8'h00;
      rx_m[i] = 8'h00;
    end
    instr_m = 8'h00;
    rxcnt_m = 8'h00;
    done_m  = 1'b0;
    ovr_m   = 1'b0;
    irqen_m = 2'b00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return instr_m;
    if (a >= 8'h01 && a <= 8'h05) return tx_m[a - 8'h01];
    if (a == 8'h06) return rxcnt_m;
`ifdef SPI_SLAVE_IRQ_EN
    if (a == 8'h07) return {6'b0, irqen_m};
`endif
    if (a == 8'h08) return {5'b0, ovr_m, done_m, 1'b0};
    if (a >= 8'h09 && a <= 8'h0D) return rx_m[a - 8'h09];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a >= 8'h01 && a <= 8'h05) tx_m[a - 8'h01] = d;
    if (a == 8'h08) begin
      if (d[1]) done_m = 1'b0;
      if (d[2]) ovr_m  = 1'b0;
    end
`ifdef SPI_SLAVE_IRQ_EN
    if (a == 8'h07) irqen_m = d[1:0];
`endif
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    d = prdata;
  endtask

  // Host write while the target is idle: the model follows it
  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    apb_write(a, d);
    model_write(a, d);
  endtask

  task automatic apply_tbl(input int lo, input int hi);
    logic [7:0] rd;
    for (int i = lo; i < hi; i++) begin
      if (tbl[i].wr) begin
        host_write(tbl[i].addr, tbl[i].val);
      end else begin
        apb_read(tbl[i].addr, rd);
        chk($sformatf("tbl%0d_reg%02h", i, tbl[i].addr), rd, tbl[i].val);
      end
    end
  endtask

  task automatic check_all_regs(input string tag);
    logic [7:0] rd;
    for (int a = 0; a < 16; a++) begin
      apb_read(8'(a), rd);
      chk($sformatf("%s_reg%02h", tag, a), rd, model_read(8'(a)));
    end
`ifdef SPI_SLAVE_IRQ_EN
    chk({tag, "_irq"}, {7'b0, irq}, {7'b0, |({ovr_m, done_m} & irqen_m)});
`endif
  endtask

  // Half an SCLK period: 6 pclk, so pclk runs at 12x SCLK
  task automatic half();
    repeat (6) @(negedge pclk);
  endtask

  task automatic spi_shift(input int nbits);
    for (int k = 0; k < nbits; k++) begin
      sclk = 1'b0;
      mosi = mo_buf[k / 8][7 - (k % 8)];
      half();
      mi_buf[k / 8][7 - (k % 8)] = miso;
      sclk = 1'b1;
      half();
    end
  endtask

  // Full frame of nbits plus model update and MISO checks of completed bytes
  task automatic run_frame(input int nbits, input string tag);
    int nb, nd;
    logic [7:0] exp_mi;
    for (int i = 0; i < 16; i++) mi_buf[i] = 8'h00;
    cs = 1'b0;
    half();
    spi_shift(nbits);
    half();
    cs = 1'b1;
    repeat (10) @(negedge pclk);

    nb = nbits / 8;
    nd = (nb > 0) ? nb - 1 : 0;
    for (int k = 0; k < nb; k++) begin
      exp_mi = (k == 0 || k > 5) ? 8'hFF : tx_m[k - 1];
      chk($sformatf("%s_miso%0d", tag, k), mi_buf[k], exp_mi);
    end
    if (nb >= 1) instr_m = mo_buf[0];
    rxcnt_m = 8'h00;
    for (int k = 0; k < nd && k < 5; k++) begin
      rx_m[k] = mo_buf[k + 1];
      rxcnt_m++;
    end
    if (nd > 5) ovr_m = 1'b1;
    done_m = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_reset, hi_reset, lo_setup, hi_setup, lo_p2, hi_p2, lo_p3, hi_p3;
    logic [7:0] rd;
    logic [7:0] mask_v;
    int ndata, part;

    // Vector tables
    lo_reset = tbl.size();
    for (int a = 0; a < 16; a++) tbl.push_back('{0, 8'(a), 8'h00});
    tbl.push_back('{0, 8'hFF, 8'h00});
    hi_reset = tbl.size();

    lo_setup = tbl.size();
    tbl.push_back('{1, 8'h01, 8'hA5});
    tbl.push_back('{1, 8'h02, 8'h3C});
    tbl.push_back('{1, 8'h03, 8'hFF});
    tbl.push_back('{1, 8'h04, 8'h00});
    tbl.push_back('{1, 8'h05, 8'h81});
    hi_setup = tbl.size();

    lo_p2 = tbl.size();
    tbl.push_back('{0, 8'h00, 8'h9F});
    tbl.push_back('{0, 8'h01, 8'hA5});
    tbl.push_back('{0, 8'h05, 8'h81});
    tbl.push_back('{0, 8'h06, 8'h05});
    tbl.push_back('{0, 8'h08, 8'h02});
    tbl.push_back('{0, 8'h09, 8'h11});
    tbl.push_back('{0, 8'h0A, 8'h22});
    tbl.push_back('{0, 8'h0B, 8'h33});
    tbl.push_back('{0, 8'h0C, 8'h44});
    tbl.push_back('{0, 8'h0D, 8'h55});
    hi_p2 = tbl.size();

    lo_p3 = tbl.size();
    tbl.push_back('{0, 8'h06, 8'h05});
    tbl.push_back('{0, 8'h08, 8'h06});
    tbl.push_back('{0, 8'h09, 8'hA1});
    tbl.push_back('{0, 8'h0D, 8'hA5});
    tbl.push_back('{1, 8'h08, 8'h06});
    tbl.push_back('{0, 8'h08, 8'h00});
    hi_p3 = tbl.size();

    // Reset
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    sclk = 1'b1; cs = 1'b1; mosi = 1'b0;
    model_reset();
    repeat (5) @(negedge pclk);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    chk("reset_prdata", prdata, 8'h00);
    chk("reset_miso", {7'b0, miso}, 8'h01);
    chk("pready", {7'b0, pready}, 8'h01);
    apply_tbl(lo_reset, hi_reset);

    // Nominal frame: instruction 0x9F + 5 data bytes
    apply_tbl(lo_setup, hi_setup);
    mo_buf[0] = 8'h9F;
    for (int i = 1; i <= 5; i++) mo_buf[i] = 8'(8'h11 * i);
    run_frame(48, "nominal");
    apply_tbl(lo_p2, hi_p2);

    // Overrun: 7 data bytes
    mo_buf[0] = 8'h9F;
    for (int i = 1; i <= 7; i++) mo_buf[i] = 8'(8'hA0 + i);
    run_frame(64, "overrun");
    apply_tbl(lo_p3, hi_p3);
    check_all_regs("overrun");

    // CS rises after instruction + 12 bits: partial nibble dropped
    mo_buf[0] = 8'h03; mo_buf[1] = 8'h5A; mo_buf[2] = 8'hF0;
    run_frame(20, "partial");
    check_all_regs("partial");

    // TX write and STATUS read while a frame is in flight
    mo_buf[0] = 8'h0B; mo_buf[1] = 8'hC3; mo_buf[2] = 8'h3C;
    fork
      run_frame(24, "busy");
      begin
        repeat (40) @(negedge pclk);
        apb_write(8'h01, 8'h77);
        apb_read(8'h08, rd);
        chk("busy_status", rd, {5'b0, ovr_m, done_m, 1'b1});
      end
    join
    check_all_regs("busy");

    // Randomised frames against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) host_write(8'(i + 1), 8'($urandom));
      host_write(8'($urandom_range(0, 15)), 8'($urandom));
      for (int i = 0; i < 16; i++) mo_buf[i] = 8'($urandom);
      ndata = $urandom_range(0, 7);
      part  = (ndata == 5) ? 0 : $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) run_frame($urandom_range(1, 7), $sformatf("rnd%0d", r));
      else run_frame(8 * (1 + ndata) + part, $sformatf("rnd%0d", r));
      check_all_regs($sformatf("rnd%0d", r));
      mask_v = 8'($urandom);
      host_write(8'h08, mask_v);
      apb_read(8'h08, rd);
      chk($sformatf("rnd%0d_w1c", r), rd, model_read(8'h08));
    end

`ifdef SPI_SLAVE_IRQ_EN
    host_write(8'h08, 8'h06);
    host_write(8'h07, 8'h01);
    mo_buf[0] = 8'h55; mo_buf[1] = 8'h66;
    run_frame(16, "irq_on");
    chk("irq_done", {7'b0, irq}, 8'h01);
    host_write(8'h08, 8'h02);
    @(negedge pclk);
    chk("irq_cleared", {7'b0, irq}, 8'h00);
    host_write(8'h07, 8'h00);
    run_frame(16, "irq_off");
    chk("irq_masked", {7'b0, irq}, 8'h00);
    check_all_regs("irq");
`endif

    // Reset in the middle of a frame
    mo_buf[0] = 8'h9F; mo_buf[1] = 8'hE7;
    cs = 1'b0;
    half();
    spi_shift(12);
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    cs = 1'b1; sclk = 1'b1;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    model_reset();
    repeat (5) @(negedge pclk);
    chk("midrst_miso", {7'b0, miso}, 8'h01);
    apply_tbl(lo_reset, hi_reset);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
